// File: rtl/bp_me_wormhole_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wormhole_link_arbiter
// Purpose  : Packet-granular round-robin sharing of one wormhole link by N
//            source links; data/valid/ready pass through combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_wormhole_link_arbiter #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int num_src_p    = 2,
  localparam int src_id_width_lp = $clog2(num_src_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_src_p*flit_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_ready_and_o,
  output logic [flit_width_p-1:0]           dst_data_o,
  output logic                              dst_v_o,
  input  logic                              dst_ready_and_i,
  output logic                              grant_v_o,
  output logic [src_id_width_lp-1:0]        grant_id_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [src_id_width_lp-1:0] c_last_rst = src_id_width_lp'(num_src_p - 1);
  localparam logic [len_width_p-1:0]     c_len_one  = len_width_p'(1);

  state_t                       r_state;
  logic [src_id_width_lp-1:0]   r_grant;
  logic [src_id_width_lp-1:0]   r_last;
  logic                         r_hdr;
  logic [len_width_p-1:0]       r_cnt;

  logic [flit_width_p-1:0]      w_src_flit [num_src_p];
  logic [src_id_width_lp-1:0]   w_winner;
  logic [src_id_width_lp-1:0]   w_cand;
  logic                         w_found;
  logic                         w_xfer;
  logic                         w_last_flit;
  logic [len_width_p-1:0]       w_len;

  for (genvar g = 0; g < num_src_p; g++) begin : g_unpack
    assign w_src_flit[g] = src_data_i[g*flit_width_p +: flit_width_p];
  end

  // Round-robin search begins one past the most recently served source.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= num_src_p; i++) begin
      w_cand = src_id_width_lp'((int'(r_last) + i) % num_src_p);
      if (!w_found && src_v_i[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign dst_data_o = w_src_flit[r_grant];
  assign dst_v_o    = (r_state == ST_LOCK) && src_v_i[r_grant];
  assign grant_v_o  = (r_state == ST_LOCK);
  assign grant_id_o = r_grant;

  always_comb begin
    src_ready_and_o = '0;
    if (r_state == ST_LOCK) begin
      src_ready_and_o[r_grant] = dst_ready_and_i;
    end
  end

  assign w_len       = dst_data_o[len_offset_p +: len_width_p];
  assign w_xfer      = dst_v_o && dst_ready_and_i;
  assign w_last_flit = r_hdr ? (w_len == '0) : (r_cnt == c_len_one);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= c_last_rst;
      r_hdr   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_hdr   <= 1'b1;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer) begin
            if (w_last_flit) begin
              r_last  <= r_grant;
              r_hdr   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (r_hdr) begin
              r_cnt <= w_len;
              r_hdr <= 1'b0;
            end else begin
              r_cnt <= r_cnt - c_len_one;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wormhole_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_wormhole_link_arbiter
// Purpose  : Table vectors plus scoreboarded packet sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_wormhole_link_arbiter;

  logic         clk;
  logic         reset_n;
  logic [127:0] src_data;
  logic [1:0]   src_v;
  logic [1:0]   src_ready;
  logic [63:0]  dst_data;
  logic         dst_v;
  logic         dst_ready;
  logic         grant_v;
  logic         grant_id;

  bp_me_wormhole_link_arbiter #(
    .flit_width_p(64),
    .len_width_p (4),
    .len_offset_p(0),
    .num_src_p   (2)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .src_data_i     (src_data),
    .src_v_i        (src_v),
    .src_ready_and_o(src_ready),
    .dst_data_o     (dst_data),
    .dst_v_o        (dst_v),
    .dst_ready_and_i(dst_ready),
    .grant_v_o      (grant_v),
    .grant_id_o     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        rdy;
    logic        exp_dv;
    logic [1:0]  exp_rdy;
    logic        exp_gv;
    logic        exp_gid;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        id;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        expq[$];
  logic [63:0] sq0[$];
  logic [63:0] sq1[$];
  logic        en0, en1;
  logic        s_dv, s_gv, s_gid;
  logic [1:0]  s_rdy;
  logic [63:0] s_data;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive();
    src_v[0] = en0 && (sq0.size() != 0);
    src_v[1] = en1 && (sq1.size() != 0);
    src_data[63:0]   = src_v[0] ? sq0[0] : 64'h0;
    src_data[127:64] = src_v[1] ? sq1[0] : 64'h0;
  endtask

  // Queues one packet on a source and records its flits as expected output.
  task automatic send(input int src, input int len, input logic [7:0] tag);
    logic [63:0] f;
    exp_t        e;
    for (int k = 0; k <= len; k++) begin
      if (k == 0) f = {8'(src), tag, 16'h0, 28'h0, 4'(len)};
      else        f = {8'(src), tag, 16'(k), 32'($urandom)};
      if (src == 0) sq0.push_back(f);
      else          sq1.push_back(f);
      e.data = f;
      e.id   = (src != 0);
      expq.push_back(e);
    end
  endtask

  task automatic cycle();
    logic [1:0] acc;
    exp_t       e;
    @(negedge clk);
    s_dv   = dst_v;
    s_data = dst_data;
    s_gv   = grant_v;
    s_gid  = grant_id;
    s_rdy  = src_ready;
    acc    = src_v & src_ready;
    if (dst_v && dst_ready) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_xfer: got data %h, required no transfer", dst_data);
      end else begin
        e = expq.pop_front();
        chk("xfer_data", dst_data, e.data);
        chk("xfer_id", 64'(grant_id), 64'(e.id));
        chk("xfer_src_ready", 64'(src_ready), 64'(2'b01 << e.id));
      end
    end
    @(posedge clk);
    #1;
    if (acc[0]) void'(sq0.pop_front());
    if (acc[1]) void'(sq1.pop_front());
    drive();
  endtask

  task automatic drain(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    chk({name, "_pending"}, 64'(expq.size()), 64'd0);
    chk({name, "_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    reset_n   = 1'b0;
    src_v     = '0;
    src_data  = '0;
    dst_ready = 1'b1;
    en0       = 1'b1;
    en1       = 1'b1;

    // Single packet from src0, then a one-flit packet from src1.
    vecs[0] = '{2'b01, 64'hA0A0_0000_0000_0002, 64'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0};
    vecs[1] = '{2'b01, 64'hA0A0_0000_0000_0002, 64'h0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 64'hA0A0_0000_0000_0002};
    vecs[2] = '{2'b01, 64'hA0A0_1111_0000_0101, 64'h0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 64'hA0A0_1111_0000_0101};
    vecs[3] = '{2'b01, 64'hA0A0_2222_0000_0202, 64'h0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 64'hA0A0_2222_0000_0202};
    vecs[4] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0};
    vecs[5] = '{2'b10, 64'h0, 64'hB1B1_0000_0000_0000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0};
    vecs[6] = '{2'b10, 64'h0, 64'hB1B1_0000_0000_0000, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 64'hB1B1_0000_0000_0000};
    vecs[7] = '{2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0};

    repeat (2) @(negedge clk);
    chk("rst_dst_v", 64'(dst_v), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_grant_v", 64'(grant_v), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_dst_data", dst_data, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      src_v            = vecs[i].v;
      src_data[63:0]   = vecs[i].d0;
      src_data[127:64] = vecs[i].d1;
      dst_ready        = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_dst_v", i), 64'(dst_v), 64'(vecs[i].exp_dv));
      chk($sformatf("vec%0d_src_ready", i), 64'(src_ready), 64'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_grant_v", i), 64'(grant_v), 64'(vecs[i].exp_gv));
      if (vecs[i].exp_gv) chk($sformatf("vec%0d_grant_id", i), 64'(grant_id), 64'(vecs[i].exp_gid));
      if (vecs[i].exp_dv) chk($sformatf("vec%0d_dst_data", i), dst_data, vecs[i].exp_data);
      @(posedge clk);
      #1;
    end

    // Round-robin: both sources offer zero-length packets back to back.
    send(0, 0, 8'h10);
    send(1, 0, 8'h11);
    send(0, 0, 8'h12);
    send(1, 0, 8'h13);
    drive();
    drain("rr", 8);
    cycle();
    chk("rr_idle_after", 64'(s_gv), 64'd0);

    // Lock under contention: src0 appears while src1 holds a len=3 packet.
    send(1, 3, 8'h20);
    drive();
    cycle();
    cycle();
    send(0, 0, 8'h21);
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lock_rdy0", 64'(s_rdy[0]), 64'd0);
      chk("lock_gid", 64'(s_gid), 64'd1);
    end
    drain("lock", 2);

    // Backpressure on a len=1 packet.
    send(0, 1, 8'h30);
    drive();
    cycle();
    chk("bp_idle_bubble", 64'(s_gv), 64'd0);
    cycle();
    dst_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_stall_dv", 64'(s_dv), 64'd1);
      chk("bp_stall_data", s_data, sq0[0]);
      chk("bp_stall_rdy", 64'(s_rdy), 64'd0);
    end
    dst_ready = 1'b1;
    cycle();
    chk("bp_last_gv", 64'(s_gv), 64'd1);
    cycle();
    chk("bp_exit_gv", 64'(s_gv), 64'd0);
    chk("bp_pending", 64'(expq.size()), 64'd0);

    // Maximum length field.
    send(1, 15, 8'h40);
    drive();
    drain("maxlen", 17);
    cycle();
    chk("maxlen_idle", 64'(s_gv), 64'd0);

    // Source drops valid mid-packet; lock must hold.
    send(0, 3, 8'h50);
    drive();
    cycle();
    cycle();
    cycle();
    en0 = 1'b0;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("drop_gv", 64'(s_gv), 64'd1);
      chk("drop_dv", 64'(s_dv), 64'd0);
      chk("drop_gid", 64'(s_gid), 64'd0);
    end
    en0 = 1'b1;
    drive();
    drain("drop", 2);

    // Asynchronous reset mid-packet.
    send(1, 5, 8'h60);
    drive();
    cycle();
    cycle();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_dst_v", 64'(dst_v), 64'd0);
    chk("arst_grant_v", 64'(grant_v), 64'd0);
    chk("arst_src_ready", 64'(src_ready), 64'd0);
    expq.delete();
    sq0.delete();
    sq1.delete();
    @(posedge clk);
    #1;
    send(0, 0, 8'h70);
    send(1, 0, 8'h71);
    drive();
    reset_n = 1'b1;
    drain("post_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
